// File: rtl/picorv_mem_arbiter.sv
// Two-port round-robin arbiter sharing one PicoRV32 native-bus slave.
// A watchdog force-completes grants the slave never acknowledges.
module picorv_mem_arbiter #(
  parameter int unsigned          AddrWidth     = 32,
  parameter int unsigned          DataWidth     = 32,
  parameter int unsigned          TimeoutCycles = 1024,
  parameter logic [DataWidth-1:0] ErrData       = 32'hDEADBEEF
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   m0_valid_i,
  input  logic [AddrWidth-1:0]   m0_addr_i,
  input  logic [DataWidth-1:0]   m0_wdata_i,
  input  logic [DataWidth/8-1:0] m0_wstrb_i,
  output logic                   m0_ready_o,
  output logic [DataWidth-1:0]   m0_rdata_o,
  input  logic                   m1_valid_i,
  input  logic [AddrWidth-1:0]   m1_addr_i,
  input  logic [DataWidth-1:0]   m1_wdata_i,
  input  logic [DataWidth/8-1:0] m1_wstrb_i,
  output logic                   m1_ready_o,
  output logic [DataWidth-1:0]   m1_rdata_o,
  output logic                   s_valid_o,
  output logic [AddrWidth-1:0]   s_addr_o,
  output logic [DataWidth-1:0]   s_wdata_o,
  output logic [DataWidth/8-1:0] s_wstrb_o,
  input  logic [DataWidth-1:0]   s_rdata_i,
  input  logic                   s_ready_i,
  output logic                   timeout_o,
  output logic                   busy_o
);

  localparam int unsigned WdogWidth = $clog2(TimeoutCycles);
  localparam logic [WdogWidth-1:0] WdogMax = WdogWidth'(TimeoutCycles - 1);

  typedef enum logic [1:0] {IDLE, GNT0, GNT1} state_e;

  state_e               state_q, state_d;
  logic                 rr_q, rr_d;
  logic [WdogWidth-1:0] wdog_q, wdog_d;

  logic                 port;
  logic                 req_valid;
  logic                 rsp_valid;
  logic [DataWidth-1:0] rsp_data;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of process ordering.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      rr_q    <= 1'b0;
      wdog_q  <= '0;
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
      wdog_q  <= wdog_d;
    end
  end

  // NOTE: every output and next-state variable gets a default first so no
  // path through the case leaves a latch behind.
  always_comb begin
    state_d   = state_q;
    rr_d      = rr_q;
    wdog_d    = wdog_q;
    port      = (state_q == GNT1);
    req_valid = 1'b0;
    rsp_valid = 1'b0;
    rsp_data  = '0;
    s_valid_o = 1'b0;
    s_addr_o  = '0;
    s_wdata_o = '0;
    s_wstrb_o = '0;
    timeout_o = 1'b0;
    busy_o    = 1'b0;

    case (state_q)
      IDLE: begin
        if (m0_valid_i && (!m1_valid_i || !rr_q)) begin
          state_d = GNT0;
        end else if (m1_valid_i) begin
          state_d = GNT1;
        end
      end
      GNT0, GNT1: begin
        busy_o    = 1'b1;
        req_valid = port ? m1_valid_i : m0_valid_i;
        s_valid_o = req_valid;
        s_addr_o  = port ? m1_addr_i  : m0_addr_i;
        s_wdata_o = port ? m1_wdata_i : m0_wdata_i;
        s_wstrb_o = port ? m1_wstrb_i : m0_wstrb_i;
        if (!req_valid) begin
          // Requester abandoned the transfer: release without moving priority.
          state_d = IDLE;
          wdog_d  = '0;
        end else if (s_ready_i) begin
          rsp_valid = 1'b1;
          rsp_data  = s_rdata_i;
          state_d   = IDLE;
          rr_d      = ~port;
          wdog_d    = '0;
        end else if (wdog_q == WdogMax) begin
          s_valid_o = 1'b0;
          rsp_valid = 1'b1;
          rsp_data  = ErrData;
          timeout_o = 1'b1;
          state_d   = IDLE;
          rr_d      = ~port;
          wdog_d    = '0;
        end else begin
          wdog_d = wdog_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    m0_ready_o = rsp_valid & ~port;
    m1_ready_o = rsp_valid &  port;
    m0_rdata_o = port ? '0 : rsp_data;
    m1_rdata_o = port ? rsp_data : '0;
  end

endmodule

// File: doc/picorv_mem_arbiter.md
Name: picorv_mem_arbiter

Overview:
- Two-port round-robin arbiter. Lets two PicoRV32-native-bus requesters share one native-bus slave (uart_ram or the cache adapter): port 0 is the core, port 1 is a boot loader/debug master.
- Grants one transaction at a time and holds the grant until the slave asserts ready.
- A watchdog completes any transaction the slave never acknowledges, so a requester cannot hang forever.

Parameters:
AddrWidth, 32, address width of all ports
DataWidth, 32, data width; wstrb width = DataWidth/8
TimeoutCycles, 1024, granted cycles without slave ready before forced completion (>=2)
ErrData, 32'hDEADBEEF, rdata returned to the requester on timeout

Ports:
clk_i  in  1  clock
rst_ni  in  1  asynchronous active-low reset
m0_valid_i  in  1  requester 0 request valid (held until m0_ready_o)
m0_addr_i  in  AddrWidth  requester 0 address
m0_wdata_i  in  DataWidth  requester 0 write data
m0_wstrb_i  in  DataWidth/8  requester 0 byte strobes, 0 = read
m0_ready_o  out  1  requester 0 transaction complete (1-cycle pulse)
m0_rdata_o  out  DataWidth  requester 0 read data, valid with m0_ready_o
m1_valid_i, m1_addr_i, m1_wdata_i, m1_wstrb_i, m1_ready_o, m1_rdata_o: same widths and meaning for requester 1
s_valid_o  out  1  slave request valid
s_addr_o  out  AddrWidth  slave address
s_wdata_o  out  DataWidth  slave write data
s_wstrb_o  out  DataWidth/8  slave byte strobes
s_rdata_i  in  DataWidth  slave read data
s_ready_i  in  1  slave transaction complete
timeout_o  out  1  1-cycle pulse on forced completion
busy_o  out  1  a grant is active

Behaviour:
- Reset (async assert, sync deassert):
  - state = IDLE, rr_ptr = 0 (port 0 has priority first), watchdog = 0.
  - All outputs are 0: s_valid_o, s_addr_o, s_wdata_o, s_wstrb_o, m*_ready_o, m*_rdata_o, timeout_o, busy_o.
- FSM states: IDLE, GNT0, GNT1.
- IDLE:
  - Only m0_valid_i: go to GNT0. Only m1_valid_i: go to GNT1.
  - Both valid: grant the port selected by rr_ptr.
  - Neither valid: stay in IDLE.
  - s_valid_o = 0 in IDLE. The arbitration decision is registered, so the first s_valid_o appears 1 cycle after request valid.
- GNTn, slave-side outputs:
  - s_valid_o = mn_valid_i.
  - s_addr_o, s_wdata_o and s_wstrb_o are driven combinationally from port n.
  - busy_o = 1.
- GNTn, requester-side outputs:
  - mn_ready_o = s_ready_i and mn_rdata_o = s_rdata_i, both combinational.
  - The non-granted port sees ready = 0 and rdata = 0.
- Completion: s_ready_i high in GNTn.
  - Go to IDLE and set rr_ptr = ~n.
  - Clear the watchdog.
  - The next grant comes no earlier than the cycle after IDLE, giving exactly 1 bubble cycle between back-to-back transactions.
- Requester drops valid while granted (protocol violation):
  - Go to IDLE the next cycle. rr_ptr is not changed, and no ready is returned.
  - s_valid_o follows the dropped valid immediately, so it is 0 that cycle.
- Watchdog:
  - Counts every GNTn cycle in which s_ready_i = 0, and saturates at TimeoutCycles-1.
  - The cycle the count equals TimeoutCycles-1 with s_ready_i still 0: force s_valid_o = 0.
  - Same cycle: pulse mn_ready_o = 1 with mn_rdata_o = ErrData and pulse timeout_o = 1.
  - Then go to IDLE and set rr_ptr = ~n.
  - s_ready_i and timeout in the same cycle: s_ready_i wins, timeout_o stays 0 and real data is returned.
- Slave-side outputs in IDLE: s_addr_o, s_wdata_o and s_wstrb_o are 0.
- s_ready_i in IDLE is ignored.
- Reset mid-grant: state returns to IDLE immediately and all outputs go to 0 asynchronously. The in-flight transaction is abandoned without a ready.
- Fairness: with both ports continuously requesting, grants alternate 0,1,0,1. No port waits more than one other transaction.

Test Plan:
- Single read, port 0:
  - Stimulus: m0_valid=1, addr=0x100, wstrb=0. Slave returns ready 3 cycles after s_valid with rdata 0x12345678.
  - Required: s_valid_o rises 1 cycle after m0_valid. m0_ready_o pulses with m0_rdata_o=0x12345678. m1_ready_o stays 0.
- Single write, port 1:
  - Stimulus: m1 addr=0x200, wdata=0xA5A5A5A5, wstrb=4'b0011.
  - Required: the slave sees exactly these values, and m1_ready_o pulses once.
- Simultaneous requests from reset, both held continuously, 4 transactions, slave ready 1 cycle after valid:
  - Required: grant order is 0,1,0,1, with 1 idle cycle between each transaction.
- Timeout:
  - Stimulus: TimeoutCycles=8, slave never asserts ready on an m0 read.
  - Required: after 8 granted cycles, m0_ready_o=1, m0_rdata_o=0xDEADBEEF and timeout_o=1, all for 1 cycle. s_valid_o is 0 that cycle. The next m1 request is then granted.
- Ready coincides with timeout:
  - Stimulus: s_ready_i arrives in cycle TimeoutCycles.
  - Required: real rdata is returned and timeout_o=0.
- Reset mid-grant:
  - Stimulus: assert rst_ni=0 while in GNT1 with s_valid_o=1.
  - Required: all outputs read 0 in the same cycle. After release, a pending m0 request is granted first (rr_ptr=0).
